axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- Single-port, AXI-style SRAM slave directly downstream of the IFU/LSU RAM arbiter; consumes the arbiter's sram-side ar/r/aw/w channels.
- Single-beat 64-bit transfers only; no b channel, so a write is complete at the w handshake.
- Read and write paths are independent FSMs sharing one word array.
- Configurable read latency and address window; out-of-window reads return SLVERR, out-of-window writes are dropped.

Parameters:
- DEPTH, 4096, number of 64-bit words in the array (power of 2).
- BASE_ADDR, 64'h8000_0000, byte address of word 0.
- RD_LAT, 2, cycles from the ar handshake edge to r_valid assertion (legal range 1..15).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ar_valid  in  1  read address valid.
- ar_addr  in  64  read byte address; bits [2:0] ignored.
- ar_ready  out  1  read address accepted.
- r_valid  out  1  read data valid.
- r_ready  in  1  read data consumed.
- r_data  out  64  read data word.
- r_rresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- r_last  out  1  equals r_valid (single beat).
- aw_valid  in  1  write address valid.
- aw_addr  in  64  write byte address; bits [2:0] ignored.
- aw_ready  out  1  write address accepted.
- w_valid  in  1  write data valid.
- w_data  in  64  write data.
- w_strb  in  8  byte enables; bit i enables w_data[8i+7:8i].
- w_ready  out  1  write data accepted.

Behaviour:
- Reset (reset=0, async) forces both FSMs to IDLE: ar_ready=1, aw_ready=1, r_valid=0, r_last=0, w_ready=0, r_data=0, r_rresp=0, latency counter=0.
- Reset mid-transaction drops the transaction silently. The array is not reset, and contents are retained across reset.
- Address decode: in-range iff BASE_ADDR <= addr < BASE_ADDR+DEPTH*8. index = (addr-BASE_ADDR)[log2(DEPTH)+2:3]. Use a 64-bit compare; no wrap-around.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: ar_ready=1. On ar_valid, latch index and in-range flag; go to R_WAIT with cnt=RD_LAT-1. If RD_LAT=1, go straight to R_RESP and capture data on the same edge.
  - R_WAIT: ar_ready=0, cnt decrements each cycle. At cnt==0, on the next edge capture r_data=mem[index] (or 0 if out of range) and r_rresp (00 or 10), then go to R_RESP.
  - R_RESP: r_valid=1, r_last=1. r_data and r_rresp are held stable while r_ready=0. On r_ready, go to R_IDLE; ar_ready reasserts the following cycle, so there is no back-to-back accept in the same cycle.
  - Latency: ar handshake at edge T gives r_valid high starting at edge T+RD_LAT.
- Write FSM states: W_IDLE, W_DATA.
  - W_IDLE: aw_ready=1, w_ready=0. On aw_valid, latch index and range flag; go to W_DATA.
  - W_DATA: aw_ready=0, w_ready=1. On w_valid, write the enabled bytes of mem[index] if in range, else discard. Go to W_IDLE.
  - w_valid in W_IDLE is not accepted. aw and w in the same cycle: only aw is taken; w is taken the next cycle if still valid.
- Write/read collision: a write commits at its w handshake edge. A read capturing data on that same edge sees the old value; a capture on any later edge sees the new value.
- w_strb=0: handshake completes and the array is unchanged.
- Read and write FSMs run concurrently with no mutual stalling.

Test Plan:
- Reset then idle: reset=0 for 3 cycles -> ar_ready=1, aw_ready=1, r_valid=0, w_ready=0. After reset=1, the state is unchanged.
- Full-word write then read: aw 0x8000_0010, then w data 0x1122334455667788 strb 0xFF. Next, ar 0x8000_0010 with r_ready=1 -> r_valid exactly 2 cycles after the ar handshake, r_data=0x1122334455667788, rresp=00, r_last=1.
- Partial strobe: write 0xFFFF... with strb 0x0F to the same address, then read -> 0x11223344FFFFFFFF.
- Backpressure: hold r_ready=0 for 5 cycles -> r_valid stays 1, r_data stable, ar_ready=0. r_ready=1 -> r_valid=0 next cycle, ar_ready=1.
- Out-of-range access: read 0x7FFF_FFF8 -> rresp=10, r_data=0. Write to BASE_ADDR+DEPTH*8 is dropped; a read of word 0 is unchanged.
- Collision and reset-mid-read: RD_LAT=1, w handshake on the same edge as read capture -> old data returned. Assert reset during R_WAIT -> r_valid never asserts, ar_ready=1 after release, and the array contents are intact.

Source files
------------

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-beat 64-bit AXI-style SRAM slave with independent
// read (ar/r) and write (aw/w) FSMs sharing one word array.
//
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where both valid and ready are high. A source holds valid (and its payload)
// until that edge, and valid never waits on ready. This slave never makes its
// own ready depend combinationally on the partner's valid.
module axi_sram_slave #(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic        clock,
  input  logic        reset,
  // read address channel
  input  logic        ar_valid,
  input  logic [63:0] ar_addr,
  output logic        ar_ready,
  // read data channel
  output logic        r_valid,
  input  logic        r_ready,
  output logic [63:0] r_data,
  output logic [1:0]  r_rresp,
  output logic        r_last,
  // write address channel
  input  logic        aw_valid,
  input  logic [63:0] aw_addr,
  output logic        aw_ready,
  // write data channel
  input  logic        w_valid,
  input  logic [63:0] w_data,
  input  logic [7:0]  w_strb,
  output logic        w_ready,
  // FSM state visibility for checkers
  output logic [1:0]  rd_state_dbg,
  output logic        wr_state_dbg
);

  localparam int unsigned IW        = $clog2(DEPTH);
  localparam logic [63:0] END_ADDR  = BASE_ADDR + (64'(DEPTH) * 64'd8);
  localparam logic [3:0]  LAT_INIT  = 4'(RD_LAT - 1);
  localparam bit          LAT_ONE   = (RD_LAT == 1);
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [1:0]  RESP_SLV  = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_DATA = 1'b1
  } wr_state_e;

  logic [63:0] mem [DEPTH];

  rd_state_e   rd_state_q;
  logic        ar_ready_q;
  logic        r_valid_q;
  logic [63:0] r_data_q;
  logic [1:0]  r_rresp_q;
  logic [3:0]  rd_cnt_q;
  logic [IW-1:0] rd_index_q;
  logic        rd_in_range_q;

  wr_state_e   wr_state_q;
  logic        aw_ready_q;
  logic        w_ready_q;
  logic [IW-1:0] wr_index_q;
  logic        wr_in_range_q;

  // Decoded values offered by the address channels this cycle.
  logic [IW-1:0] ar_index_d;
  logic          ar_in_range_d;
  logic [IW-1:0] aw_index_d;
  logic          aw_in_range_d;
  logic          wr_commit;

  // Address decode: 64-bit window compare with no wrap, word index from offset.
  always_comb begin
    ar_in_range_d = (ar_addr >= BASE_ADDR) && (ar_addr < END_ADDR);
    aw_in_range_d = (aw_addr >= BASE_ADDR) && (aw_addr < END_ADDR);
    ar_index_d    = IW'((ar_addr - BASE_ADDR) >> 3);
    aw_index_d    = IW'((aw_addr - BASE_ADDR) >> 3);
    wr_commit     = (wr_state_q == W_DATA) && w_valid && wr_in_range_q;
  end

  // Read FSM: accept address, count down the latency, then hold the response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_state_q    <= R_IDLE;
      ar_ready_q    <= 1'b1;
      r_valid_q     <= 1'b0;
      r_data_q      <= '0;
      r_rresp_q     <= RESP_OKAY;
      rd_cnt_q      <= '0;
      rd_index_q    <= '0;
      rd_in_range_q <= 1'b0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (ar_valid) begin
            rd_index_q    <= ar_index_d;
            rd_in_range_q <= ar_in_range_d;
            ar_ready_q    <= 1'b0;
            if (LAT_ONE) begin
              // Latency of one: capture on the accepting edge itself.
              r_data_q   <= ar_in_range_d ? mem[ar_index_d] : 64'd0;
              r_rresp_q  <= ar_in_range_d ? RESP_OKAY : RESP_SLV;
              r_valid_q  <= 1'b1;
              rd_state_q <= R_RESP;
            end else begin
              rd_cnt_q   <= LAT_INIT;
              rd_state_q <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (rd_cnt_q == 4'd0) begin
            r_data_q   <= rd_in_range_q ? mem[rd_index_q] : 64'd0;
            r_rresp_q  <= rd_in_range_q ? RESP_OKAY : RESP_SLV;
            r_valid_q  <= 1'b1;
            rd_state_q <= R_RESP;
          end else begin
            rd_cnt_q <= rd_cnt_q - 4'd1;
          end
        end
        R_RESP: begin
          // Payload stays put until consumed; ar_ready returns a cycle later.
          if (r_ready) begin
            r_valid_q  <= 1'b0;
            ar_ready_q <= 1'b1;
            rd_state_q <= R_IDLE;
          end
        end
        default: begin
          r_valid_q  <= 1'b0;
          ar_ready_q <= 1'b1;
          rd_state_q <= R_IDLE;
        end
      endcase
    end
  end

  // Write FSM: address phase then data phase; never both in one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_state_q    <= W_IDLE;
      aw_ready_q    <= 1'b1;
      w_ready_q     <= 1'b0;
      wr_index_q    <= '0;
      wr_in_range_q <= 1'b0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (aw_valid) begin
            wr_index_q    <= aw_index_d;
            wr_in_range_q <= aw_in_range_d;
            aw_ready_q    <= 1'b0;
            w_ready_q     <= 1'b1;
            wr_state_q    <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_valid) begin
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b0;
            wr_state_q <= W_IDLE;
          end
        end
        default: begin
          aw_ready_q <= 1'b1;
          w_ready_q  <= 1'b0;
          wr_state_q <= W_IDLE;
        end
      endcase
    end
  end

  // Byte-masked array write; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_commit) begin
      for (int i = 0; i < 8; i++) begin
        if (w_strb[i]) begin
          mem[wr_index_q][8*i +: 8] <= w_data[8*i +: 8];
        end
      end
    end
  end

  assign ar_ready     = ar_ready_q;
  assign r_valid      = r_valid_q;
  assign r_last       = r_valid_q;
  assign r_data       = r_data_q;
  assign r_rresp      = r_rresp_q;
  assign aw_ready     = aw_ready_q;
  assign w_ready      = w_ready_q;
  assign rd_state_dbg = rd_state_q;
  assign wr_state_dbg = wr_state_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed testbench for axi_sram_slave: main instance at default latency,
// second instance at RD_LAT=1 for the same-edge write/read collision case.
module tb_axi_sram_slave;

  logic        clock;
  logic        reset;

  logic        ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [63:0] ar_addr, r_data;
  logic [1:0]  r_rresp;
  logic        aw_valid, aw_ready, w_valid, w_ready;
  logic [63:0] aw_addr, w_data;
  logic [7:0]  w_strb;
  logic [1:0]  rd_state_dbg;
  logic        wr_state_dbg;

  logic        b_ar_valid, b_ar_ready, b_r_valid, b_r_ready, b_r_last;
  logic [63:0] b_ar_addr, b_r_data;
  logic [1:0]  b_r_rresp;
  logic        b_aw_valid, b_aw_ready, b_w_valid, b_w_ready;
  logic [63:0] b_aw_addr, b_w_data;
  logic [7:0]  b_w_strb;
  logic [1:0]  b_rd_state_dbg;
  logic        b_wr_state_dbg;

  int checks = 0;
  int errors = 0;

  logic [63:0] rd_data;
  logic [1:0]  rd_resp;
  int          rd_lat;
  logic [63:0] held_data;

  axi_sram_slave dut (
    .clock(clock), .reset(reset),
    .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_ready(ar_ready),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .r_rresp(r_rresp), .r_last(r_last),
    .aw_valid(aw_valid), .aw_addr(aw_addr), .aw_ready(aw_ready),
    .w_valid(w_valid), .w_data(w_data), .w_strb(w_strb), .w_ready(w_ready),
    .rd_state_dbg(rd_state_dbg), .wr_state_dbg(wr_state_dbg)
  );

  axi_sram_slave #(.RD_LAT(1)) dut_lat1 (
    .clock(clock), .reset(reset),
    .ar_valid(b_ar_valid), .ar_addr(b_ar_addr), .ar_ready(b_ar_ready),
    .r_valid(b_r_valid), .r_ready(b_r_ready), .r_data(b_r_data),
    .r_rresp(b_r_rresp), .r_last(b_r_last),
    .aw_valid(b_aw_valid), .aw_addr(b_aw_addr), .aw_ready(b_aw_ready),
    .w_valid(b_w_valid), .w_data(b_w_data), .w_strb(b_w_strb), .w_ready(b_w_ready),
    .rd_state_dbg(b_rd_state_dbg), .wr_state_dbg(b_wr_state_dbg)
  );

  // Clock and safety net.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Address phase then data phase on the main instance.
  task automatic do_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb);
    int n;
    @(negedge clock);
    aw_valid = 1'b1;
    aw_addr  = addr;
    n = 0;
    while (!aw_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    aw_valid = 1'b0;
    w_valid  = 1'b1;
    w_data   = data;
    w_strb   = strb;
    check("w_ready_in_data", w_ready, 1'b1);
    @(negedge clock);
    w_valid = 1'b0;
  endtask

  // Issue a read and wait (bounded) for r_valid; lat counts edges after the ar handshake.
  task automatic do_read(input logic [63:0] addr, input logic rdy,
                         output logic [63:0] data, output logic [1:0] resp, output int lat);
    int n;
    @(negedge clock);
    r_ready  = rdy;
    ar_valid = 1'b1;
    ar_addr  = addr;
    n = 0;
    while (!ar_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    ar_valid = 1'b0;
    lat = 0;
    while (!r_valid && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    data = r_data;
    resp = r_rresp;
    check("r_last", r_last, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    ar_valid = 0; ar_addr = '0; r_ready = 0;
    aw_valid = 0; aw_addr = '0; w_valid = 0; w_data = '0; w_strb = '0;
    b_ar_valid = 0; b_ar_addr = '0; b_r_ready = 1;
    b_aw_valid = 0; b_aw_addr = '0; b_w_valid = 0; b_w_data = '0; b_w_strb = '0;

    // Reset state, during and after reset.
    repeat (3) @(negedge clock);
    check("rst_ar_ready", ar_ready, 1'b1);
    check("rst_aw_ready", aw_ready, 1'b1);
    check("rst_r_valid", r_valid, 1'b0);
    check("rst_w_ready", w_ready, 1'b0);
    check("rst_r_last", r_last, 1'b0);
    check("rst_r_data", r_data, 64'd0);
    check("rst_r_rresp", r_rresp, 2'b00);
    reset = 1'b1;
    @(negedge clock);
    check("idle_ar_ready", ar_ready, 1'b1);
    check("idle_aw_ready", aw_ready, 1'b1);
    check("idle_r_valid", r_valid, 1'b0);
    check("idle_w_ready", w_ready, 1'b0);

    // Full-word write then read with r_ready high.
    do_write(64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF);
    do_read(64'h8000_0010, 1'b1, rd_data, rd_resp, rd_lat);
    check("full_lat", rd_lat, 2);
    check("full_data", rd_data, 64'h1122_3344_5566_7788);
    check("full_resp", rd_resp, 2'b00);
    check("full_ar_ready_held", ar_ready, 1'b0);
    @(negedge clock);
    check("full_r_valid_drop", r_valid, 1'b0);
    check("full_ar_ready_back", ar_ready, 1'b1);

    // Partial strobe: low four bytes only.
    do_write(64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    do_read(64'h8000_0010, 1'b1, rd_data, rd_resp, rd_lat);
    check("partial_data", rd_data, 64'h1122_3344_FFFF_FFFF);
    @(negedge clock);

    // Backpressure: response held stable for five cycles.
    do_read(64'h8000_0010, 1'b0, rd_data, rd_resp, rd_lat);
    held_data = rd_data;
    check("bp_data", held_data, 64'h1122_3344_FFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_r_valid", r_valid, 1'b1);
      check("bp_r_data", r_data, 64'h1122_3344_FFFF_FFFF);
      check("bp_ar_ready", ar_ready, 1'b0);
    end
    r_ready = 1'b1;
    @(negedge clock);
    check("bp_release_r_valid", r_valid, 1'b0);
    check("bp_release_ar_ready", ar_ready, 1'b1);

    // Window edges: below base, last word, one past the end.
    do_write(64'h8000_0000, 64'hA5A5_0000_5A5A_0001, 8'hFF);
    do_write(64'h8000_7FF8, 64'h0BAD_F00D_CAFE_0002, 8'hFF);
    do_read(64'h7FFF_FFF8, 1'b1, rd_data, rd_resp, rd_lat);
    check("oor_low_resp", rd_resp, 2'b10);
    check("oor_low_data", rd_data, 64'd0);
    do_read(64'h8000_8000, 1'b1, rd_data, rd_resp, rd_lat);
    check("oor_high_resp", rd_resp, 2'b10);
    check("oor_high_data", rd_data, 64'd0);
    do_write(64'h8000_8000, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF);
    do_read(64'h8000_0000, 1'b1, rd_data, rd_resp, rd_lat);
    check("oor_wr_dropped", rd_data, 64'hA5A5_0000_5A5A_0001);
    check("word0_resp", rd_resp, 2'b00);
    do_read(64'h8000_7FFF, 1'b1, rd_data, rd_resp, rd_lat);
    check("last_word_data", rd_data, 64'h0BAD_F00D_CAFE_0002);
    check("last_word_resp", rd_resp, 2'b00);

    // Zero strobe completes the handshake but changes nothing.
    do_write(64'h8000_0010, 64'h0, 8'h00);
    check("strb0_aw_ready", aw_ready, 1'b1);
    do_read(64'h8000_0010, 1'b1, rd_data, rd_resp, rd_lat);
    check("strb0_data", rd_data, 64'h1122_3344_FFFF_FFFF);

    // aw and w together: only aw is taken, w goes on the following edge.
    @(negedge clock);
    aw_valid = 1'b1; aw_addr = 64'h8000_0018;
    w_valid = 1'b1; w_data = 64'h0123_4567_89AB_CDEF; w_strb = 8'hFF;
    check("aww_w_ready_idle", w_ready, 1'b0);
    @(negedge clock);
    aw_valid = 1'b0;
    check("aww_w_ready_data", w_ready, 1'b1);
    check("aww_aw_ready_data", aw_ready, 1'b0);
    check("aww_wr_state", wr_state_dbg, 1'b1);
    @(negedge clock);
    w_valid = 1'b0;
    check("aww_back_idle", w_ready, 1'b0);
    do_read(64'h8000_0018, 1'b1, rd_data, rd_resp, rd_lat);
    check("aww_data", rd_data, 64'h0123_4567_89AB_CDEF);

    // Collision on the RD_LAT=1 instance: capture on the commit edge sees old data.
    @(negedge clock);
    b_aw_valid = 1'b1; b_aw_addr = 64'h8000_0020;
    @(negedge clock);
    b_aw_valid = 1'b0;
    b_w_valid = 1'b1; b_w_data = 64'h0000_0000_0000_0A1D; b_w_strb = 8'hFF;
    @(negedge clock);
    b_w_valid = 1'b0;
    b_aw_valid = 1'b1;
    @(negedge clock);
    b_aw_valid = 1'b0;
    check("col_w_ready", b_w_ready, 1'b1);
    check("col_ar_ready", b_ar_ready, 1'b1);
    b_ar_valid = 1'b1; b_ar_addr = 64'h8000_0020;
    b_w_valid = 1'b1; b_w_data = 64'h0000_0000_0000_0BEE; b_w_strb = 8'hFF;
    @(negedge clock);
    b_ar_valid = 1'b0;
    b_w_valid = 1'b0;
    check("col_r_valid", b_r_valid, 1'b1);
    check("col_old_data", b_r_data, 64'h0000_0000_0000_0A1D);
    @(negedge clock);
    check("col_r_drop", b_r_valid, 1'b0);
    @(negedge clock);
    b_ar_valid = 1'b1;
    @(negedge clock);
    b_ar_valid = 1'b0;
    check("col_lat1_valid", b_r_valid, 1'b1);
    check("col_new_data", b_r_data, 64'h0000_0000_0000_0BEE);
    @(negedge clock);

    // Reset while the main read FSM waits: the read vanishes, the array survives.
    @(negedge clock);
    r_ready = 1'b1;
    ar_valid = 1'b1; ar_addr = 64'h8000_0010;
    @(negedge clock);
    ar_valid = 1'b0;
    check("midrst_in_wait", rd_state_dbg, 2'd1);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check("midrst_r_valid_low", r_valid, 1'b0);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("midrst_no_r_valid", r_valid, 1'b0);
    end
    check("midrst_ar_ready", ar_ready, 1'b1);
    do_read(64'h8000_0010, 1'b1, rd_data, rd_resp, rd_lat);
    check("midrst_array_kept", rd_data, 64'h1122_3344_FFFF_FFFF);
    check("midrst_lat", rd_lat, 2);
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
